// File: rtl/cdb_pkg.sv
// Shared opcode/field constants and the write-back decode for the CDB arbiter.
package cdb_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_SD  = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;

    localparam int OPC_LSB    = 0;
    localparam int RD_ALU_LSB = 10;
    localparam int RD_LD_LSB  = 4;
    localparam int REG_ADDR_W = 3;

    typedef struct packed {
        logic                  wr_en;
        logic [REG_ADDR_W-1:0] dest;
    } wb_t;

    // Stores and unknown opcodes still broadcast but never write the register file.
    function automatic wb_t decode_wb(input logic [15:0] inst);
        wb_t wb;
        wb = '0;
        case (inst[OPC_LSB +: 4])
            OP_ADD, OP_SUB, OP_MUL: begin
                wb.wr_en = 1'b1;
                wb.dest  = inst[RD_ALU_LSB +: REG_ADDR_W];
            end
            OP_LD: begin
                wb.wr_en = 1'b1;
                wb.dest  = inst[RD_LD_LSB +: REG_ADDR_W];
            end
            default: wb = '0;
        endcase
        return wb;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic NUM_SRC-way round-robin arbiter: search starts at ptr and wraps;
// on an advancing grant the pointer moves just past the winner.
module rr_arbiter #(
    parameter  int NUM_SRC = 3,
    localparam int PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic               advance,
    output logic [NUM_SRC-1:0] grant,
    output logic [PTR_W-1:0]   ptr
);

    logic             found;
    logic [PTR_W-1:0] winner;
    logic [PTR_W-1:0] ptr_next;
    int               idx;

    always_comb begin
        grant  = '0;
        winner = ptr;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(ptr) + k) % NUM_SRC;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = PTR_W'(idx);
            end
        end
        ptr_next = (int'(winner) == NUM_SRC - 1) ? '0 : PTR_W'(int'(winner) + 1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-source holding registers, round-robin select, registered
// broadcast with write-back decode. Optional CDB_BYPASS_EN lets an isolated request skip its holding register.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter  int NUM_SRC = 3,
    parameter  int DATA_W  = 16,
    parameter  int INST_W  = 16,
    localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC*INST_W-1:0] src_inst,
    output logic                      cdb_valid,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [INST_W-1:0]         cdb_inst,
    output logic [SRC_W-1:0]          cdb_src,
    output logic                      cdb_wr_en,
    output logic [REG_ADDR_W-1:0]     cdb_dest,
    output logic                      busy
);

    logic [NUM_SRC-1:0] hold_valid;
    logic [DATA_W-1:0]  hold_data [NUM_SRC];
    logic [INST_W-1:0]  hold_inst [NUM_SRC];

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] grant;
    logic [SRC_W-1:0]   rr_ptr;
    logic               bypass;

    logic [SRC_W-1:0]   win_idx;
    logic [DATA_W-1:0]  win_data;
    logic [INST_W-1:0]  win_inst;
    wb_t                win_wb;

`ifdef CDB_BYPASS_EN
    assign bypass = ~|hold_valid && |src_valid &&
                    ((src_valid & (src_valid - NUM_SRC'(1))) == '0);
`else
    assign bypass = 1'b0;
`endif

    // A bypassed request competes in the arbiter so the pointer advances as for a normal grant.
    assign req       = bypass ? src_valid : hold_valid;
    assign src_ready = ~hold_valid | grant;
    assign busy      = |hold_valid | cdb_valid;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .advance (1'b1),
        .grant   (grant),
        .ptr     (rr_ptr)
    );

    always_comb begin
        win_idx  = '0;
        win_data = '0;
        win_inst = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                win_idx  = SRC_W'(i);
                win_data = bypass ? src_data[i*DATA_W +: DATA_W] : hold_data[i];
                win_inst = bypass ? src_inst[i*INST_W +: INST_W] : hold_inst[i];
            end
        end
        win_wb = decode_wb(win_inst);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                hold_data[i] <= '0;
                hold_inst[i] <= '0;
            end
        end else if (!bypass) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_data[i]  <= src_data[i*DATA_W +: DATA_W];
                    hold_inst[i]  <= src_inst[i*INST_W +: INST_W];
                end else if (grant[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_inst  <= '0;
            cdb_src   <= '0;
            cdb_wr_en <= 1'b0;
            cdb_dest  <= '0;
        end else begin
            cdb_valid <= |req;
            if (|grant) begin
                cdb_data  <= win_data;
                cdb_inst  <= win_inst;
                cdb_src   <= win_idx;
                cdb_wr_en <= win_wb.wr_en;
                cdb_dest  <= win_wb.dest;
            end else begin
                cdb_wr_en <= 1'b0;
                cdb_dest  <= '0;
            end
        end
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Collects completed results from the functional-unit reservation stations (adders, multiplier, load/store unit).
- Selects one per cycle by round-robin arbitration and drives the registered common-data-bus broadcast.
- Feeds the CDB write-back stage: FP register write, load data fetch and store commit.
- Decodes each winner's opcode so write-back receives a ready-made destination address and write strobe.

Parameters:
- NUM_SRC, 3, number of requesting sources (index 0 adders, 1 multiplier, 2 load/store).
- DATA_W, 16, result/address word width.
- INST_W, 16, instruction word width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- src_valid  in  NUM_SRC  per-source result valid.
- src_ready  out  NUM_SRC  per-source accept; a transfer occurs when src_valid & src_ready are both high at a rising edge.
- src_data  in  NUM_SRC*DATA_W  packed results; source i occupies [i*DATA_W +: DATA_W].
- src_inst  in  NUM_SRC*INST_W  packed originating instructions, same packing.
- cdb_valid  out  1  broadcast valid, one cycle per result.
- cdb_data  out  DATA_W  broadcast result (ld/sd: effective address).
- cdb_inst  out  INST_W  broadcast instruction.
- cdb_src  out  $clog2(NUM_SRC)  index of the winning source.
- cdb_wr_en  out  1  register-file write strobe.
- cdb_dest  out  3  destination FP register.
- busy  out  1  high while any holding entry or a broadcast is valid.

Behaviour:
- Reset, asynchronous on reset_n low:
  - all holding entries invalid; round-robin pointer = 0;
  - cdb_valid, cdb_wr_en, busy = 0; cdb_data, cdb_inst, cdb_dest, cdb_src = 0;
  - src_ready = all ones on the first cycle after release.
- Reset mid-operation discards every held and in-flight result; no partial broadcast.
- Holding stage: each source has a 1-entry register (hold_valid, hold_data, hold_inst).
  - src_ready[i] = ~hold_valid[i] | grant[i], combinational.
  - A source granted this cycle may load a new result in the same edge, so a sole requester gets 1 result/cycle throughput.
- Arbitration: combinational over hold_valid.
  - Search starts at the pointer and wraps modulo NUM_SRC.
  - On a grant, the pointer becomes (winner+1) mod NUM_SRC at the same edge.
  - With no requests, the pointer holds.
- Output register, loaded on every edge:
  - cdb_valid <= |hold_valid.
  - cdb_data, cdb_inst, cdb_src take the winner's values when a grant occurs; otherwise they hold their last value.
  - The winner's hold_valid clears unless it is reloaded the same edge.
- Latency: handshake at edge N -> cdb_valid high in the cycle after edge N+1 (2 edges).
- Decode of the winner's cdb_inst[3:0]:
  - 0000 add, 0001 sub, 0100 mul -> cdb_wr_en = 1, cdb_dest = inst[12:10].
  - 0010 ld -> cdb_wr_en = 1, cdb_dest = inst[6:4].
  - 0011 sd and all other opcodes -> cdb_wr_en = 0, cdb_dest = 0; the result is still broadcast.
  - cdb_wr_en and cdb_dest are registered alongside cdb_valid and are 0 whenever cdb_valid = 0.
- Fairness: with all NUM_SRC sources continuously requesting, grants rotate 0,1,2,0,... and no source waits more than NUM_SRC-1 broadcasts.
- Full condition: a held, ungranted source sees src_ready=0 and must keep valid, data and instruction stable until accepted.
- busy = |hold_valid | cdb_valid.

Optional Feature:
- Macro: CDB_BYPASS_EN.
- Defined:
  - When no hold_valid is set and exactly one src_valid is high, that source is written directly into the output register at the handshake edge, skipping its holding register.
  - Latency is 1 edge; the pointer updates as for a normal grant.
  - With two or more simultaneous requests, behaviour is identical to the undefined build.
- Undefined: every result passes through its holding register; latency is fixed at 2 edges.

Decomposition:
- Package cdb_pkg:
  - opcode constants OP_ADD=4'b0000, OP_SUB=4'b0001, OP_LD=4'b0010, OP_SD=4'b0011, OP_MUL=4'b0100;
  - field constants OPC_LSB=0, RD_ALU_LSB=10, RD_LD_LSB=4, REG_ADDR_W=3;
  - a function returning the write-enable and destination for an instruction.
- Sub-module rr_arbiter:
  - pure NUM_SRC-way round-robin;
  - inputs req and advance; outputs one-hot grant and the pointer register;
  - reusable by the reservation-station issue logic.

Test Plan:
- Reset release, then src_valid=3'b001, src_data[0]=16'h0012, inst opcode 0000 with inst[12:10]=5 -> two edges later one cycle of cdb_valid=1, cdb_data=16'h0012, cdb_wr_en=1, cdb_dest=5, cdb_src=0.
- All three sources valid every cycle for 9 cycles -> cdb_src sequence 0,1,2,0,1,2,0,1,2; cdb_valid continuous; each src_ready high exactly on the cycle it is granted.
- ld on source 2 with inst[6:4]=3 and sd on source 2 -> ld gives cdb_wr_en=1, cdb_dest=3; sd gives cdb_valid=1, cdb_wr_en=0, cdb_dest=0.
- Source 1 held while source 0 streams -> source 1 sees src_ready=0 and keeps data stable; it is granted no later than the second broadcast; no result lost or duplicated, checked against a scoreboard.
- reset_n pulsed low while 2 entries are held and cdb_valid=1 -> outputs 0 immediately (asynchronous); after release no stale broadcast appears and the pointer restarts at 0.
- With CDB_BYPASS_EN, a single isolated request -> cdb_valid one edge after the handshake; a simultaneous 3-way request -> 2-edge latency and the same order as without the macro.
